imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writes a program image into the core's instruction memory over a byte stream. It is the writer side of the instruction-fetch read path.
- Receives a framed little-endian byte stream: 2-byte word count, then the data words, then a 1-byte XOR checksum.
- Packs bytes into s-bit words and issues single-cycle instruction-memory write strobes.
- Holds the processor in reset (core_hold) until a load completes with a correct checksum.

Parameters:
- s, 32, instruction word width in bits. Must be a multiple of 8. BYTES = s/8.
- ADDR_W, 10, instruction-memory word-address width.
- BASE_ADDR, 0, word address at which the first loaded word is written.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERR.
- byte_valid  input  1  byte_data holds a valid byte.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts a byte this cycle. Transfer occurs when byte_valid && byte_ready.
- imem_we  output  1  instruction-memory write strobe, exactly one cycle per word.
- imem_addr  output  ADDR_W  word address of the write.
- imem_wdata  output  s  word to write.
- core_hold  output  1  1 = processor held in reset.
- done  output  1  load finished with a good checksum.
- error  output  1  load failed (length overflow or bad checksum).
- words_loaded  output  ADDR_W+1  count of words committed in the current or last load.

Behaviour:
- Reset (asynchronous, any state, including mid-load):
  - state=IDLE.
  - core_hold=1.
  - byte_ready, imem_we, done, error = 0.
  - imem_addr, imem_wdata, words_loaded, length, checksum, byte index = 0.
  - Words already written to instruction memory are not undone.
- States: IDLE, LEN0, LEN1, DATA, WRITE, CHK, DONE, ERR.
- byte_ready is 1 only in LEN0, LEN1, DATA and CHK. It is a registered state decode, independent of byte_valid.
- IDLE:
  - start -> LEN0.
  - On that transition: clear words_loaded, checksum and byte index; done=0, error=0; core_hold=1.
- LEN0: on transfer, len[7:0]=byte -> LEN1.
- LEN1: on transfer, len[15:8]=byte, then:
  - len > 2^ADDR_W -> ERR.
  - len == 0 -> CHK.
  - otherwise -> DATA.
- DATA:
  - On each transfer, byte k (k = 0..BYTES-1) goes to word bits [8k+7:8k] (little-endian).
  - checksum ^= byte.
  - After byte BYTES-1 is transferred -> WRITE.
- WRITE (exactly one cycle):
  - imem_we=1, imem_addr=(BASE_ADDR + words_loaded) mod 2^ADDR_W, imem_wdata=assembled word.
  - words_loaded increments.
  - If the new words_loaded == len -> CHK, else -> DATA.
  - Latency: one cycle from the last byte transfer of a word to its write strobe.
- CHK: on transfer, byte == checksum -> DONE, else -> ERR. Length bytes are excluded from the checksum.
- DONE: done=1, core_hold=0. Holds until start, which re-enters LEN0 with core_hold=1 and done=0.
- ERR: error=1, core_hold=1. Holds until start, which behaves as in DONE.
- start is ignored in LEN0, LEN1, DATA, WRITE and CHK. There is no abort other than reset.
- byte_valid without byte_ready: the byte is not consumed and no state changes.
- Address wrap: BASE_ADDR + index wraps modulo 2^ADDR_W. The maximum len of 2^ADDR_W fills the whole memory exactly once.
- All outputs are registered. imem_addr and imem_wdata hold their last values outside WRITE.

Decomposition:
- Package loader_pkg:
  - state enum loader_state_t (the 8 states above).
  - localparam BYTES_PER_WORD = s/8.
  - localparam LEN_W = 16.
- Sub-module byte_packer:
  - Byte-index counter plus s-bit assembly register.
  - Inputs: clk, reset, clear, load, byte_data.
  - Outputs: word, last_byte.
- All FSM, checksum and address logic stays in imem_loader.

Test Plan:
- Reset -> core_hold=1; done=0, error=0, imem_we=0, byte_ready=0, words_loaded=0.
- Good load: start, then bytes 02 00 | 13 00 50 00 | 93 00 10 00 | C0 ->
  - imem_we at addr 0 with 0x00500013.
  - imem_we at addr 1 with 0x00100093.
  - done=1, core_hold=0, words_loaded=2.
- Same frame with checksum C1 -> both writes occur, then error=1, core_hold=1, done=0. A subsequent start plus the good frame gives done=1.
- Boundary lengths:
  - Bytes 00 00 00 -> done=1, no imem_we.
  - Bytes 01 04 (len=0x401 with ADDR_W=10) -> error=1 after LEN1, no writes.
- Backpressure: byte_valid toggled every other cycle, with a byte offered during the WRITE cycle -> byte_ready=0 in WRITE, that byte is not consumed, and the final written data is unchanged.
- Reset asserted after 2 data bytes of word 0 -> immediately IDLE, core_hold=1, no imem_we. A subsequent full good load succeeds with the correct words.

Source files
------------

// File: rtl/loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
// Shared types and constants for the instruction-memory loader.
//   loader_state_t  : loader FSM states
//   S_DEFAULT       : default instruction word width in bits
//   BYTES_PER_WORD  : bytes per default-width instruction word
//   LEN_W           : width of the frame length field
//   word_bytes()    : bytes per word for a given word width
// ---------------------------------------------------------------------------
package loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLen0,
        StLen1,
        StData,
        StWrite,
        StChk,
        StDone,
        StErr
    } loader_state_t;

    localparam int unsigned S_DEFAULT = 32;
    localparam int unsigned LEN_W     = 16;

    function automatic int unsigned word_bytes(input int unsigned width);
        return width / 8;
    endfunction

    localparam int unsigned BYTES_PER_WORD = word_bytes(S_DEFAULT);

endpackage

// File: rtl/byte_packer.sv
// ---------------------------------------------------------------------------
// byte_packer
// Assembles a little-endian word from a stream of bytes.
// Ports:
//   clk        : system clock
//   reset      : asynchronous active-high reset (clears index and word)
//   clear      : synchronous restart of the byte index
//   load       : store byte_data at the current byte index
//   byte_data  : incoming byte
//   word       : assembled word register
//   last_byte  : current index is the final byte of the word
// ---------------------------------------------------------------------------
module byte_packer
    import loader_pkg::*;
#(
    parameter int unsigned NBYTES = BYTES_PER_WORD
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  load,
    input  logic [7:0]            byte_data,
    output logic [8*NBYTES-1:0]   word,
    output logic                  last_byte
);

    localparam int unsigned IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    logic [IDX_W-1:0]      r_idx;
    logic [8*NBYTES-1:0]   r_word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx  <= '0;
            r_word <= '0;
        end else if (clear) begin
            r_idx  <= '0;
        end else if (load) begin
            r_word[8*r_idx +: 8] <= byte_data;
            r_idx                <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
        end
    end

    assign word      = r_word;
    assign last_byte = (r_idx == LAST_IDX);

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Loads a program image into instruction memory from a framed byte stream:
//   len[7:0], len[15:8], len words (little-endian bytes), XOR checksum byte.
// The core is held in reset until a load ends with a matching checksum.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   start         : begin a load from IDLE, DONE or ERR
//   byte_valid    : byte_data is valid
//   byte_data     : stream byte
//   byte_ready    : loader accepts a byte this cycle
//   imem_we       : one-cycle write strobe per word
//   imem_addr     : word address of the write
//   imem_wdata    : word to write
//   core_hold     : 1 holds the processor in reset
//   done          : load completed with good checksum
//   error         : length overflow or bad checksum
//   words_loaded  : words committed in the current or last load
// ---------------------------------------------------------------------------
module imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned s         = S_DEFAULT,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [s-1:0]      imem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int unsigned BYTES = word_bytes(s);

    loader_state_t      r_state;
    loader_state_t      w_state_d;

    logic               r_byte_ready;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [s-1:0]       r_wdata;
    logic               r_hold;
    logic               r_done;
    logic               r_error;
    logic [ADDR_W:0]    r_words;
    logic [LEN_W-1:0]   r_len;
    logic [7:0]         r_chk;

    logic               w_xfer;
    logic               w_restart;
    logic               w_pack_load;
    logic [s-1:0]       w_word;
    logic [s-1:0]       w_word_merged;
    logic               w_last_byte;
    logic [LEN_W-1:0]   w_len_full;
    logic               w_too_long;
    logic [ADDR_W:0]    w_words_inc;
    logic               w_last_word;
    logic [ADDR_W-1:0]  w_addr;

    assign w_xfer      = byte_valid && r_byte_ready;
    assign w_restart   = start && ((r_state == StIdle) || (r_state == StDone) ||
                                   (r_state == StErr));
    assign w_pack_load = w_xfer && (r_state == StData);

    byte_packer #(
        .NBYTES (BYTES)
    ) u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (w_restart),
        .load      (w_pack_load),
        .byte_data (byte_data),
        .word      (w_word),
        .last_byte (w_last_byte)
    );

    // The final byte lands in the packer on the same edge that enters WRITE, so
    // the registered write data is built from the packer word plus that byte.
    always_comb begin
        w_word_merged            = w_word;
        w_word_merged[s-8 +: 8]  = byte_data;
    end

    assign w_len_full  = {byte_data, r_len[7:0]};
    assign w_too_long  = 32'(w_len_full) > (32'd1 << ADDR_W);
    assign w_words_inc = r_words + 1'b1;
    assign w_last_word = (32'(w_words_inc) == 32'(r_len));
    // Address wraps naturally by truncation to ADDR_W bits.
    assign w_addr      = ADDR_W'(BASE_ADDR) + r_words[ADDR_W-1:0];

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle, StDone, StErr: begin
                if (start) w_state_d = StLen0;
            end
            StLen0: begin
                if (w_xfer) w_state_d = StLen1;
            end
            StLen1: begin
                if (w_xfer) begin
                    if (w_too_long)             w_state_d = StErr;
                    else if (w_len_full == '0)  w_state_d = StChk;
                    else                        w_state_d = StData;
                end
            end
            StData: begin
                if (w_xfer && w_last_byte) w_state_d = StWrite;
            end
            StWrite: begin
                w_state_d = w_last_word ? StChk : StData;
            end
            StChk: begin
                if (w_xfer) w_state_d = (byte_data == r_chk) ? StDone : StErr;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= StIdle;
            r_byte_ready <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_hold       <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_words      <= '0;
            r_len        <= '0;
            r_chk        <= '0;
        end else begin
            r_state      <= w_state_d;
            r_byte_ready <= (w_state_d == StLen0) || (w_state_d == StLen1) ||
                            (w_state_d == StData) || (w_state_d == StChk);
            // WRITE always lasts one cycle, so entering it is the strobe.
            r_we         <= (w_state_d == StWrite);
            if (w_state_d == StWrite) begin
                r_addr  <= w_addr;
                r_wdata <= w_word_merged;
            end

            unique case (r_state)
                StIdle, StDone, StErr: begin
                    if (start) begin
                        r_words <= '0;
                        r_chk   <= '0;
                        r_done  <= 1'b0;
                        r_error <= 1'b0;
                        r_hold  <= 1'b1;
                    end
                end
                StLen0: begin
                    if (w_xfer) r_len[7:0] <= byte_data;
                end
                StLen1: begin
                    if (w_xfer) begin
                        r_len[15:8] <= byte_data;
                        if (w_too_long) r_error <= 1'b1;
                    end
                end
                StData: begin
                    if (w_xfer) r_chk <= r_chk ^ byte_data;
                end
                StWrite: begin
                    r_words <= w_words_inc;
                end
                StChk: begin
                    if (w_xfer) begin
                        if (byte_data == r_chk) begin
                            r_done <= 1'b1;
                            r_hold <= 1'b0;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign byte_ready   = r_byte_ready;
    assign imem_we      = r_we;
    assign imem_addr    = r_addr;
    assign imem_wdata   = r_wdata;
    assign core_hold    = r_hold;
    assign done         = r_done;
    assign error        = r_error;
    assign words_loaded = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
// Directed self-checking bench for imem_loader (s=32, ADDR_W=10, BASE_ADDR=0).
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_imem_loader;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_hold;
    logic        done;
    logic        error;
    logic [10:0] words_loaded;

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    imem_loader #(
        .s         (32),
        .ADDR_W    (10),
        .BASE_ADDR (0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_hold    (core_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Log every write strobe cycle; a stuck strobe shows up as extra entries.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_wdata);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= 50) begin
            n_fail++;
            $display("FAIL byte_ready_timeout: byte %02h not accepted, got ready=%b want 1",
                     b, byte_ready);
        end
        @(negedge clk);
        byte_valid = 1'b0;
        for (int g = 0; g < gap; g++) @(negedge clk);
    endtask

    task automatic send_frame(input byte_q_t f, input int gap);
        foreach (f[i]) send_byte(f[i], gap);
    endtask

    task automatic wait_end();
        int n = 0;
        while (!(done === 1'b1 || error === 1'b1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n >= 20) begin
            n_fail++;
            $display("FAIL end_timeout: done=%b error=%b, want one of them 1", done, error);
        end
    endtask

    byte_q_t good_frame = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00,
                            8'h93, 8'h00, 8'h10, 8'h00, 8'hC0};
    byte_q_t bad_frame  = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00,
                            8'h93, 8'h00, 8'h10, 8'h00, 8'hC1};

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (core_hold !== 1'b1) begin n_fail++; $display("FAIL reset_hold: got %b want 1", core_hold); end
        n_checks++;
        if ({done, error, imem_we, byte_ready} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got done/err/we/rdy=%b want 0000",
                     {done, error, imem_we, byte_ready});
        end
        n_checks++;
        if (words_loaded !== 11'd0) begin n_fail++; $display("FAIL reset_words: got %0d want 0", words_loaded); end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL idle_ready: got %b want 0", byte_ready); end
    endtask

    task automatic check_good_result(input string tag);
        n_checks++;
        if ({done, error, core_hold} !== 3'b100) begin
            n_fail++;
            $display("FAIL %s_status: got done/err/hold=%b want 100", tag, {done, error, core_hold});
        end
        n_checks++;
        if (words_loaded !== 11'd2) begin n_fail++; $display("FAIL %s_words: got %0d want 2", tag, words_loaded); end
        n_checks++;
        if (wr_addr_q.size() != 2) begin
            n_fail++;
            $display("FAIL %s_wr_count: got %0d want 2", tag, wr_addr_q.size());
        end else begin
            n_checks++;
            if (wr_addr_q[0] !== 10'd0 || wr_data_q[0] !== 32'h0050_0013) begin
                n_fail++;
                $display("FAIL %s_wr0: got addr %0d data %08h want addr 0 data 00500013",
                         tag, wr_addr_q[0], wr_data_q[0]);
            end
            n_checks++;
            if (wr_addr_q[1] !== 10'd1 || wr_data_q[1] !== 32'h0010_0093) begin
                n_fail++;
                $display("FAIL %s_wr1: got addr %0d data %08h want addr 1 data 00100093",
                         tag, wr_addr_q[1], wr_data_q[1]);
            end
        end
    endtask

    task automatic test_good_load();
        clear_log();
        pulse_start();
        n_checks++;
        if (byte_ready !== 1'b1 || core_hold !== 1'b1) begin
            n_fail++;
            $display("FAIL good_len0: got ready=%b hold=%b want 1 1", byte_ready, core_hold);
        end
        send_frame(good_frame, 0);
        wait_end();
        check_good_result("good");
        n_checks++;
        if (imem_addr !== 10'd1 || imem_wdata !== 32'h0010_0093) begin
            n_fail++;
            $display("FAIL good_hold_outputs: got addr %0d data %08h want 1 00100093",
                     imem_addr, imem_wdata);
        end
    endtask

    task automatic test_bad_checksum();
        clear_log();
        pulse_start();
        send_frame(bad_frame, 0);
        wait_end();
        n_checks++;
        if ({done, error, core_hold} !== 3'b011) begin
            n_fail++;
            $display("FAIL badchk_status: got done/err/hold=%b want 011", {done, error, core_hold});
        end
        n_checks++;
        if (wr_addr_q.size() != 2) begin
            n_fail++;
            $display("FAIL badchk_wr_count: got %0d want 2", wr_addr_q.size());
        end
        clear_log();
        pulse_start();
        n_checks++;
        if ({done, error, core_hold} !== 3'b001) begin
            n_fail++;
            $display("FAIL restart_flags: got done/err/hold=%b want 001", {done, error, core_hold});
        end
        send_frame(good_frame, 0);
        wait_end();
        check_good_result("reload");
    endtask

    task automatic test_zero_len();
        byte_q_t f = '{8'h00, 8'h00, 8'h00};
        clear_log();
        pulse_start();
        send_frame(f, 0);
        wait_end();
        n_checks++;
        if ({done, error, core_hold} !== 3'b100) begin
            n_fail++;
            $display("FAIL zero_status: got done/err/hold=%b want 100", {done, error, core_hold});
        end
        n_checks++;
        if (wr_addr_q.size() != 0 || words_loaded !== 11'd0) begin
            n_fail++;
            $display("FAIL zero_writes: got %0d writes words=%0d want 0 0",
                     wr_addr_q.size(), words_loaded);
        end
    endtask

    task automatic test_overlong();
        byte_q_t f = '{8'h01, 8'h04};
        clear_log();
        pulse_start();
        send_frame(f, 0);
        n_checks++;
        if ({done, error, core_hold, byte_ready} !== 4'b0110) begin
            n_fail++;
            $display("FAIL overlong_status: got done/err/hold/rdy=%b want 0110",
                     {done, error, core_hold, byte_ready});
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (wr_addr_q.size() != 0) begin
            n_fail++;
            $display("FAIL overlong_writes: got %0d want 0", wr_addr_q.size());
        end
    endtask

    // len = 0x400 fills the memory exactly; word i holds value i.
    task automatic test_full_memory();
        byte_q_t    f;
        logic [7:0] chk = 8'h00;
        logic [31:0] w;
        f.push_back(8'h00);
        f.push_back(8'h04);
        for (int i = 0; i < 1024; i++) begin
            w = 32'(i);
            for (int k = 0; k < 4; k++) begin
                f.push_back(w[8*k +: 8]);
                chk ^= w[8*k +: 8];
            end
        end
        f.push_back(chk);
        clear_log();
        pulse_start();
        send_frame(f, 0);
        wait_end();
        n_checks++;
        if ({done, error} !== 2'b10 || words_loaded !== 11'd1024) begin
            n_fail++;
            $display("FAIL full_status: got done/err=%b words=%0d want 10 1024",
                     {done, error}, words_loaded);
        end
        n_checks++;
        if (wr_addr_q.size() != 1024) begin
            n_fail++;
            $display("FAIL full_wr_count: got %0d want 1024", wr_addr_q.size());
        end else begin
            n_checks++;
            if (wr_addr_q[1023] !== 10'h3FF || wr_data_q[1023] !== 32'd1023 ||
                wr_addr_q[512] !== 10'd512 || wr_data_q[512] !== 32'd512) begin
                n_fail++;
                $display("FAIL full_entries: got [512]=%0d/%0d [1023]=%0d/%0d want 512/512 1023/1023",
                         wr_addr_q[512], wr_data_q[512], wr_addr_q[1023], wr_data_q[1023]);
            end
        end
    endtask

    task automatic test_backpressure();
        clear_log();
        pulse_start();
        send_byte(8'h02, 1);
        send_byte(8'h00, 1);
        send_byte(8'h13, 1);
        send_byte(8'h00, 1);
        send_byte(8'h50, 1);
        send_byte(8'h00, 0);
        // Now in the WRITE cycle: offer a stray byte that must not be taken.
        n_checks++;
        if (byte_ready !== 1'b0 || imem_we !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_write_cycle: got ready=%b we=%b want 0 1", byte_ready, imem_we);
        end
        byte_valid = 1'b1;
        byte_data  = 8'hFF;
        @(negedge clk);
        byte_valid = 1'b0;
        @(negedge clk);
        send_byte(8'h93, 1);
        send_byte(8'h00, 1);
        send_byte(8'h10, 1);
        send_byte(8'h00, 1);
        send_byte(8'hC0, 1);
        wait_end();
        check_good_result("bp");
    endtask

    task automatic test_reset_midload();
        byte_q_t f = '{8'h02, 8'h00, 8'h13, 8'h00};
        clear_log();
        pulse_start();
        send_frame(f, 0);
        reset = 1'b1;
        #1;
        n_checks++;
        if ({core_hold, byte_ready, done, error, imem_we} !== 5'b10000 || words_loaded !== 11'd0) begin
            n_fail++;
            $display("FAIL midreset_state: got hold/rdy/done/err/we=%b words=%0d want 10000 0",
                     {core_hold, byte_ready, done, error, imem_we}, words_loaded);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (wr_addr_q.size() != 0) begin
            n_fail++;
            $display("FAIL midreset_writes: got %0d want 0", wr_addr_q.size());
        end
        clear_log();
        pulse_start();
        send_frame(good_frame, 0);
        wait_end();
        check_good_result("after_reset");
    endtask

    initial begin
        test_reset();
        test_good_load();
        test_bad_checksum();
        test_zero_len();
        test_overlong();
        test_backpressure();
        test_reset_midload();
        test_full_memory();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
